fp_sub_arbiter: RTL and testbench

- Shares one pipelined FP32 subtract core among NUM_REQ requesters in the SZ first-stage datapath, e.g. predictor lanes computing value minus prediction.
- Core: fixed latency, always-valid inputs, no backpressure. This block drives its operand registers and tags each issue with a requester ID.
- Round-robin arbitration; routes each result back to the issuing requester in issue order.

---
 rtl/fp_sub_arb_pkg.sv | 44 ++++
 rtl/fp_sub_tag_pipe.sv | 36 +++
 rtl/fp_sub_arbiter.sv | 126 ++++++++++++
 tb/tb_fp_sub_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sub_arb_pkg.sv
// fp_sub_arb_pkg: shared types and helpers for the FP32 subtract-core arbiter.
//   FP32_W          operand / result width
//   DEF_SUB_LATENCY default latency of the shared subtract core
//   MAX_REQ         largest supported requester count
//   tag_t           in-flight tag {valid, requester id}
//   rr_pick         round-robin one-hot pick from a valid vector and pointer
package fp_sub_arb_pkg;

  localparam int unsigned FP32_W          = 32;
  localparam int unsigned DEF_SUB_LATENCY = 11;
  localparam int unsigned MAX_REQ         = 8;
  localparam int unsigned TAG_ID_W        = 3;

  // The id field is sized for the largest supported requester count so
  // one tag type serves every NUM_REQ setting.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // First asserted bit at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  valid,
    input logic [TAG_ID_W-1:0] ptr,
    input int unsigned         n
  );
    logic [MAX_REQ-1:0] g;
    logic               found;
    int unsigned        idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = (32'(ptr) + k) % n;
        if (!found && valid[idx[TAG_ID_W-1:0]]) begin
          g[idx[TAG_ID_W-1:0]] = 1'b1;
          found                = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/fp_sub_tag_pipe.sv
// fp_sub_tag_pipe: DEPTH-deep shift register of tags running alongside the
// subtract core so each result can be routed back to its issuer.
//   clk, rst   clock, asynchronous active-high reset (clears all tags)
//   tag_in     tag entering stage 0
//   tag_out    tag at the last stage
//   any_valid  OR of all stage valid bits
module fp_sub_tag_pipe
  import fp_sub_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_SUB_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic any_valid
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) any_valid = any_valid | stage[i].valid;
    tag_out = stage[DEPTH-1];
  end

endmodule

// File: rtl/fp_sub_arbiter.sv
// fp_sub_arbiter: round-robin sharing of one pipelined FP32 subtract core
// among NUM_REQ requesters; results return in issue order to the issuer.
//   clk, rst    clock, asynchronous active-high reset
//   req_valid   per-requester operand valid
//   req_ready   per-requester grant, one-hot or zero
//   req_a/req_b per-requester minuend/subtrahend, slice i = [32*i+31:32*i]
//   core_a/b    registered operands to the core
//   core_res    core result, SUB_LATENCY cycles after core_a/core_b
//   res_valid   one-hot result strobe; res_data registered result
//   busy        any operation in flight (issue reg, tag pipe, output stage)
// Optional (macro FP_SUB_ARB_STATS_EN):
//   grant_cnt   per-requester saturating accept counters, 16 bits each
//   stall_cnt   saturating count of cycles with a valid requester not granted
module fp_sub_arbiter
  import fp_sub_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned SUB_LATENCY = DEF_SUB_LATENCY,
  parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*FP32_W-1:0]   req_a,
  input  logic [NUM_REQ*FP32_W-1:0]   req_b,
  output logic [FP32_W-1:0]           core_a,
  output logic [FP32_W-1:0]           core_b,
  input  logic [FP32_W-1:0]           core_res,
  output logic [NUM_REQ-1:0]          res_valid,
  output logic [FP32_W-1:0]           res_data,
  output logic                        busy
`ifdef FP_SUB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]       grant_cnt,
  output logic [15:0]                 stall_cnt
`endif
);

  logic [ID_W-1:0]    ptr;
  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] pick;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win_id;
  logic               accept;
  tag_t               issue_tag;
  tag_t               last_tag;
  logic               pipe_any;
  logic               unused_pick;

  // Grant is forced low during reset so req_ready reads 0 while rst is held.
  always_comb begin
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = req_valid;
    pick                   = rr_pick(valid_ext, TAG_ID_W'(ptr), NUM_REQ);
    grant                  = rst ? '0 : pick[NUM_REQ-1:0];
    accept                 = |grant;
    win_id                 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_id = ID_W'(i);
    end
  end

  assign unused_pick = ^pick;
  assign req_ready   = grant;

  // Issue stage: operands and their tag are registered together, so the tag
  // pipe lines up with the core input and the result lands SUB_LATENCY+1
  // edges after the accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      core_a    <= '0;
      core_b    <= '0;
      issue_tag <= '0;
    end else if (accept) begin
      ptr       <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
      core_a    <= req_a[win_id*FP32_W +: FP32_W];
      core_b    <= req_b[win_id*FP32_W +: FP32_W];
      issue_tag <= '{valid: 1'b1, id: TAG_ID_W'(win_id)};
    end else begin
      issue_tag <= '0;
    end
  end

  fp_sub_tag_pipe #(
    .DEPTH (SUB_LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .tag_in    (issue_tag),
    .tag_out   (last_tag),
    .any_valid (pipe_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= '0;
      res_data  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        res_valid[i] <= last_tag.valid && (last_tag.id == TAG_ID_W'(i));
      end
      if (last_tag.valid) res_data <= core_res;
    end
  end

  assign busy = issue_tag.valid | pipe_any | (|res_valid);

`ifdef FP_SUB_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF))
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
      if ((|(req_valid & ~grant)) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_sub_arbiter.sv
// Testbench for fp_sub_arbiter with a behavioural FP32 subtract core stub.
// Optional checks for FP_SUB_ARB_STATS_EN are compiled when that macro is set.
module tb_fp_sub_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned L = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [31:0]     core_a;
  logic [31:0]     core_b;
  logic [31:0]     core_res;
  logic [N-1:0]    res_valid;
  logic [31:0]     res_data;
  logic            busy;
`ifdef FP_SUB_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  fp_sub_arbiter #(
    .NUM_REQ     (N),
    .SUB_LATENCY (L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .core_a    (core_a),
    .core_b    (core_b),
    .core_res  (core_res),
    .res_valid (res_valid),
    .res_data  (res_data),
    .busy      (busy)
`ifdef FP_SUB_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // FP32 <-> FP64 for normal numbers and zero; test values are exact.
  function automatic logic [63:0] f2d(input logic [31:0] f);
    if (f[30:0] == 31'd0) return {f[31], 63'd0};
    return {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2f(input logic [63:0] d);
    logic [10:0] e;
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
    return d2f($realtobits($bitstoreal(f2d(a)) - $bitstoreal(f2d(b))));
  endfunction

  // Stub core: L-cycle pipelined A-B, never reset.
  logic [31:0] core_pipe [L];
  always @(posedge clk) begin
    core_pipe[0] <= fsub(core_a, core_b);
    for (int i = 1; i < L; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_res = core_pipe[L-1];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int unsigned id;
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int unsigned mptr     = 0;
  int unsigned last_acc = 0;
  int unsigned m_idx;
  int unsigned m_id;
  logic [N-1:0] eg;

  // Reference round-robin model plus result scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mptr = 0;
      chk("ready_in_reset", 64'(req_ready), 64'd0);
    end else begin
      if (res_valid != '0) begin
        if (q.size() == 0) begin
          chk("unexpected_res", 64'(res_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("res_id", 64'(res_valid), 64'(1 << e.id));
          chk("res_data", 64'(res_data), 64'(e.data));
          chk("res_latency", 64'(cyc), 64'(e.due));
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        chk("res_missing", 64'(res_valid), 64'(1 << q[0].id));
        void'(q.pop_front());
      end
      eg   = '0;
      m_id = 0;
      for (int k = 0; k < N; k++) begin
        m_idx = (mptr + k) % N;
        if (eg == '0 && req_valid[m_idx]) begin
          eg[m_idx] = 1'b1;
          m_id      = m_idx;
        end
      end
      chk("grant", 64'(req_ready), 64'(eg));
      if (eg != '0) begin
        q.push_back('{id: m_id, data: fsub(req_a[m_id*32 +: 32], req_b[m_id*32 +: 32]),
                      due: cyc + 13});
        last_acc = cyc + 1;
        mptr     = (m_id + 1) % N;
      end
    end
  end

  task automatic drain();
    for (int w = 0; w < 60 && q.size() != 0; w++) @(negedge clk);
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  typedef struct {
    int unsigned id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [5];
    logic got;
    tbl[0] = '{id: 2, a: 32'h40400000, b: 32'h3F800000, exp: 32'h40000000};
    tbl[1] = '{id: 0, a: 32'h41200000, b: 32'h40A00000, exp: 32'h40A00000};
    tbl[2] = '{id: 3, a: 32'h3F800000, b: 32'h40000000, exp: 32'hBF800000};
    tbl[3] = '{id: 1, a: 32'h42C80000, b: 32'hC2C80000, exp: 32'h43480000};
    tbl[4] = '{id: 1, a: 32'h00000000, b: 32'h00000000, exp: 32'h00000000};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready",     64'(req_ready), 64'd0);
    chk("rst_core_a",    64'(core_a),    64'd0);
    chk("rst_core_b",    64'(core_b),    64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data",  64'(res_data),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);

    // All four valid for 8 cycles: strict rotation 0,1,2,3,0,1,2,3.
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = 32'h40400000 + 32'(i << 23);
      req_b[i*32 +: 32] = 32'h3F800000;
    end
    @(posedge clk); #1;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_seq", 64'(req_ready), 64'(1 << (k % 4)));
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();
`ifdef FP_SUB_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'd2);
    chk("stall_cnt", 64'(stall_cnt), 64'd8);
`endif

    // Single issues from a vector table.
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      req_valid                   = 4'(1 << tbl[t].id);
      req_a[tbl[t].id*32 +: 32]   = tbl[t].a;
      req_b[tbl[t].id*32 +: 32]   = tbl[t].b;
      @(posedge clk); #1;
      req_valid = '0;
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk);
        if (res_valid != '0) begin
          got = 1'b1;
          chk("tbl_id",   64'(res_valid), 64'(1 << tbl[t].id));
          chk("tbl_data", 64'(res_data),  64'(tbl[t].exp));
          chk("tbl_wait", 64'(w),         64'd12);
        end
      end
      chk("tbl_timeout", 64'(got), 64'd1);
      drain();
    end

    // Requester 1 alone for 20 cycles, operands varying each cycle.
    @(posedge clk); #1;
    req_valid = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      req_a[32 +: 32] = 32'h40400000 + 32'(k << 16);
      req_b[32 +: 32] = 32'h3F800000;
      @(posedge clk); #1;
    end
    req_valid = '0;
    for (int w = 0; w < 30 && cyc < last_acc + 12; w++) @(negedge clk);
    chk("s3_last_res",  64'(res_valid), 64'b0010);
    chk("s3_busy_last", 64'(busy),      64'd1);
    @(negedge clk);
    chk("s3_busy_drop", 64'(busy),      64'd0);
    drain();

    // Pointer at 1 with requesters 0 and 3 pending.
    @(posedge clk); #1;
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = 4'b1001;
    @(negedge clk);
    chk("s4_first", 64'(req_ready), 64'b1000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("s4_second", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0011;
    @(negedge clk);
    chk("s4_ptr", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Reset with three operations in flight.
    @(posedge clk); #1;
    req_valid = 4'b0111;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int w = 0; w < 16; w++) begin
      @(negedge clk);
      chk("s5_no_res", 64'(res_valid), 64'd0);
    end
    chk("s5_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    chk("s5_regrant", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
